// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : ALU op codes, arbiter FSM state encoding and grant helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

   localparam logic [2:0] c_op_add = 3'b000;
   localparam logic [2:0] c_op_sub = 3'b001;
   localparam logic [2:0] c_op_mul = 3'b010;
   localparam logic [2:0] c_op_shl = 3'b011;
   localparam logic [2:0] c_op_shr = 3'b100;
   localparam logic [2:0] c_op_cmp = 3'b101;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_exec = 2'd1;
   localparam logic [1:0] c_st_resp = 2'd2;

   // One-hot grant; a lone requester always wins, contention goes to the pointer.
   function automatic logic [1:0] grant_onehot(input logic [1:0] valid, input logic ptr);
      case (valid)
         2'b01:   return 2'b01;
         2'b10:   return 2'b10;
         2'b11:   return ptr ? 2'b10 : 2'b01;
         default: return 2'b00;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// ============================================================================
// Module      : alu_arbiter_alu
// Description : Combinational 8-bit ALU with zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] op,
   output logic [7:0] result,
   output logic       zero
);

   always_comb begin
      result = 8'd0;
      case (op)
         c_op_add: result = a + b;
         c_op_sub: result = a - b;
         c_op_mul: result = a * b;
         c_op_shl: result = {a[6:0], 1'b0};
         c_op_shr: result = {1'b0, a[7:1]};
         c_op_cmp: result = (a == b) ? 8'd0 : 8'd1;
         default:  result = 8'd0;
      endcase
   end

   assign zero = (result == 8'd0);

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end for a shared 8-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter logic RR_INIT = 1'b0
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [2:0] req0_op,
   input  logic [2:0] req1_op,
   output logic [1:0] rsp_valid,
   input  logic [1:0] rsp_ready,
   output logic [7:0] rsp_result,
   output logic       rsp_zero,
   output logic       busy
);

   logic [1:0] r_state;
   logic [1:0] w_state_next;
   logic       r_ptr;
   logic       r_gnt;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [2:0] r_op;
   logic [7:0] r_result;
   logic       r_zero;
   logic [1:0] w_grant;
   logic       w_accept;
   logic       w_done;
   logic [7:0] w_alu_result;
   logic       w_alu_zero;

   assign w_grant  = grant_onehot(req_valid, r_ptr);
   assign w_accept = (r_state == c_st_idle) && (|req_valid);
   // Only the served requester's rsp_ready can complete the response.
   assign w_done   = (r_state == c_st_resp) && rsp_ready[r_gnt];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: if (w_accept) w_state_next = c_st_exec;
         c_st_exec: w_state_next = c_st_resp;
         c_st_resp: if (w_done) w_state_next = c_st_idle;
         default:   w_state_next = c_st_idle;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      busy      = (r_state != c_st_idle);
      case (r_state)
         c_st_idle: req_ready = w_grant;
         c_st_resp: rsp_valid = r_gnt ? 2'b10 : 2'b01;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr    <= RR_INIT;
         r_gnt    <= 1'b0;
         r_a      <= 8'd0;
         r_b      <= 8'd0;
         r_op     <= 3'd0;
         r_result <= 8'd0;
         r_zero   <= 1'b1;
      end else begin
         if (w_accept) begin
            r_gnt <= w_grant[1];
            r_a   <= w_grant[1] ? req1_a  : req0_a;
            r_b   <= w_grant[1] ? req1_b  : req0_b;
            r_op  <= w_grant[1] ? req1_op : req0_op;
         end
         if (r_state == c_st_exec) begin
            r_result <= w_alu_result;
            r_zero   <= w_alu_zero;
         end
         // Priority moves on completion, even when the other side never asked.
         if (w_done) begin
            r_ptr <= ~r_gnt;
         end
      end
   end

   alu_arbiter_alu alu (
      .a      (r_a),
      .b      (r_b),
      .op     (r_op),
      .result (w_alu_result),
      .zero   (w_alu_zero)
   );

   assign rsp_result = r_result;
   assign rsp_zero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0] req0_op, req1_op;
   logic [1:0] rsp_valid;
   logic [1:0] rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_zero;
   logic       busy;

   int checks;
   int failures;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] exp;
      logic       z;
   } vec_t;

   vec_t vecs [10];

   alu_arbiter #(.RR_INIT(1'b0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req0_op    (req0_op),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b00; rsp_ready = 2'b00;
      req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
      req0_op = 3'd0; req1_op = 3'd0;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      checks++; if (rsp_result !== 8'd0) begin failures++; $display("FAIL reset_result: got %0d want 0", rsp_result); end
      checks++; if (rsp_zero !== 1'b1) begin failures++; $display("FAIL reset_zero: got %b want 1", rsp_zero); end
      rst = 1'b0;
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_ptr_grant: got %b want 01", req_ready); end
      req_valid = 2'b00;
      #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_no_grant: got %b want 00", req_ready); end
   endtask

   task automatic test_single_op();
      req_valid = 2'b01; req0_a = 8'd200; req0_b = 8'd100; req0_op = 3'b000;
      req1_a = 8'hAA; req1_b = 8'h55; req1_op = 3'b010;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready: got %b want 01", req_ready); end
      tick();
      req_valid = 2'b00;
      checks++; if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
         failures++; $display("FAIL single_exec: busy=%b ready=%b rsp_valid=%b want 1/00/00", busy, req_ready, rsp_valid);
      end
      tick();
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
      checks++; if (rsp_result !== 8'd44 || rsp_zero !== 1'b0) begin
         failures++; $display("FAIL single_result: got %0d/%b want 44/0", rsp_result, rsp_zero);
      end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
         failures++; $display("FAIL single_done: busy=%b rsp_valid=%b want 0/00", busy, rsp_valid);
      end
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      apply_reset();
      req0_a = 8'd1;  req0_b = 8'd2; req0_op = 3'b000;
      req1_a = 8'd10; req1_b = 8'd3; req1_op = 3'b001;
      req_valid = 2'b11; rsp_ready = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL contend_grant%0d: got %b want %b", k, req_ready, exp_g); end
         tick();
         checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL contend_exec%0d: got %b want 00", k, req_ready); end
         tick();
         checks++; if (rsp_valid !== exp_g || rsp_result !== ((k % 2 == 0) ? 8'd3 : 8'd7)) begin
            failures++; $display("FAIL contend_rsp%0d: valid=%b result=%0d want %b/%0d", k, rsp_valid, rsp_result, exp_g, (k % 2 == 0) ? 3 : 7);
         end
         tick();
      end
      req_valid = 2'b00; rsp_ready = 2'b00;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL contend_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_backpressure();
      req_valid = 2'b10; req1_a = 8'd5; req1_b = 8'd3; req1_op = 3'b010;
      req0_a = 8'd9; req0_b = 8'd9; req0_op = 3'b000;
      #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_grant: got %b want 10", req_ready); end
      tick();
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_exec_ready: got %b want 00", req_ready); end
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++; if (rsp_valid !== 2'b10 || rsp_result !== 8'd15 || rsp_zero !== 1'b0 || req_ready !== 2'b00) begin
            failures++; $display("FAIL bp_hold%0d: valid=%b result=%0d zero=%b ready=%b want 10/15/0/00", i, rsp_valid, rsp_result, rsp_zero, req_ready);
         end
         tick();
      end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
      checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
         failures++; $display("FAIL bp_done: valid=%b busy=%b want 00/0", rsp_valid, busy);
      end
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_pending_req0: got %b want 01", req_ready); end
      req_valid = 2'b00;
   endtask

   task automatic test_alu_ops();
      logic [1:0] sel;
      vecs = '{
         '{8'd7,   8'd7,   3'b101, 8'd0,   1'b1},
         '{8'd7,   8'd7,   3'b001, 8'd0,   1'b1},
         '{8'd16,  8'd16,  3'b010, 8'd0,   1'b1},
         '{8'd7,   8'd8,   3'b101, 8'd1,   1'b0},
         '{8'd3,   8'd5,   3'b001, 8'd254, 1'b0},
         '{8'h81,  8'd0,   3'b011, 8'h02,  1'b0},
         '{8'h81,  8'd0,   3'b100, 8'h40,  1'b0},
         '{8'd9,   8'd9,   3'b110, 8'd0,   1'b1},
         '{8'd200, 8'd100, 3'b111, 8'd0,   1'b1},
         '{8'd20,  8'd13,  3'b010, 8'd4,   1'b0}
      };
      for (int i = 0; i < 10; i++) begin
         sel = i[0] ? 2'b10 : 2'b01;
         if (i[0]) begin
            req1_a = vecs[i].a; req1_b = vecs[i].b; req1_op = vecs[i].op;
            req0_a = 8'hAA;     req0_b = 8'h11;     req0_op = 3'b000;
         end else begin
            req0_a = vecs[i].a; req0_b = vecs[i].b; req0_op = vecs[i].op;
            req1_a = 8'hAA;     req1_b = 8'h11;     req1_op = 3'b000;
         end
         req_valid = sel;
         tick();
         req_valid = 2'b00;
         tick();
         checks++; if (rsp_valid !== sel || rsp_result !== vecs[i].exp || rsp_zero !== vecs[i].z) begin
            failures++; $display("FAIL alu_vec%0d: valid=%b result=%0d zero=%b want %b/%0d/%b", i, rsp_valid, rsp_result, rsp_zero, sel, vecs[i].exp, vecs[i].z);
         end
         rsp_ready = 2'b11;
         tick();
         rsp_ready = 2'b00;
      end
   endtask

   task automatic test_midop_reset();
      req_valid = 2'b10; req1_a = 8'd1; req1_b = 8'd1; req1_op = 3'b000;
      tick();
      req_valid = 2'b00;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_exec_busy: got %b want 1", busy); end
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_result !== 8'd0 || rsp_zero !== 1'b1) begin
         failures++; $display("FAIL midrst_state: busy=%b valid=%b result=%0d zero=%b want 0/00/0/1", busy, rsp_valid, rsp_result, rsp_zero);
      end
      tick();
      rst = 1'b0;
      rsp_ready = 2'b11;
      tick();
      tick();
      checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
         failures++; $display("FAIL midrst_no_rsp: valid=%b busy=%b want 00/0", rsp_valid, busy);
      end
      rsp_ready = 2'b00;
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_ptr: got %b want 01", req_ready); end
      req_valid = 2'b00;
   endtask

   task automatic test_stale_ready();
      req_valid = 2'b01; req0_a = 8'd3; req0_b = 8'd4; req0_op = 3'b000;
      tick();
      req_valid = 2'b00;
      tick();
      rsp_ready = 2'b10;
      for (int i = 0; i < 3; i++) begin
         checks++; if (rsp_valid !== 2'b01 || busy !== 1'b1 || rsp_result !== 8'd7) begin
            failures++; $display("FAIL stale_hold%0d: valid=%b busy=%b result=%0d want 01/1/7", i, rsp_valid, busy, rsp_result);
         end
         tick();
      end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
         failures++; $display("FAIL stale_done: valid=%b busy=%b want 00/0", rsp_valid, busy);
      end
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL stale_ptr_flip: got %b want 10", req_ready); end
      req_valid = 2'b00;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_single_op();
      test_contention();
      test_backpressure();
      test_alu_ops();
      test_midop_reset();
      test_stale_ready();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
